// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI slave: FSM state encoding,
// frame command codes and the default RAM byte width.
package spi_pkg;

   localparam int SPI_DATA_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_RECEIVE = 3'd1,
      ST_WAIT_TX = 3'd2,
      ST_SEND    = 3'd3,
      ST_DONE    = 3'd4
   } state_t;

   localparam logic [1:0] CMD_WR_ADDR = 2'b00;
   localparam logic [1:0] CMD_WR_DATA = 2'b01;
   localparam logic [1:0] CMD_RD_ADDR = 2'b10;
   localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

// File: rtl/spi_slave.sv
// SPI slave bridging a serial master to a RAM frame interface (clk is the bit clock).
// Optional macro SPI_RD_ORDER_EN: read-data frames are accepted only after a read-address frame.
module spi_slave
   import spi_pkg::*;
#(
   parameter int DATA_W = SPI_DATA_W
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              SS_n,
   input  logic              MOSI,
   output logic              MISO,
   output logic [DATA_W+1:0] rx_data,
   output logic              rx_valid,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_valid,
   output logic [2:0]        o_state
);

   localparam int CNT_W = $clog2(DATA_W + 2);
   localparam logic [CNT_W-1:0] LAST_RX = CNT_W'(DATA_W + 1);
   localparam logic [CNT_W-1:0] LAST_TX = CNT_W'(DATA_W - 1);

   state_t              r_state;
   logic [CNT_W-1:0]    r_cnt;
   logic [DATA_W:0]     r_shift;
   logic [DATA_W+1:0]   r_rx_data;
   logic                r_rx_valid;
   logic [DATA_W-1:0]   r_tx_byte;

   logic [DATA_W+1:0]   w_frame;
   logic [1:0]          w_cmd;
   logic                w_accept;

   // The final sample is taken straight from MOSI so the frame is complete on its last edge.
   assign w_frame = {r_shift, MOSI};
   assign w_cmd   = w_frame[DATA_W+1:DATA_W];

`ifdef SPI_RD_ORDER_EN
   logic r_rd_flag;
   assign w_accept = !((w_cmd == CMD_RD_DATA) && !r_rd_flag);
`else
   assign w_accept = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= ST_IDLE;
         r_cnt      <= '0;
         r_shift    <= '0;
         r_rx_data  <= '0;
         r_rx_valid <= 1'b0;
         r_tx_byte  <= '0;
`ifdef SPI_RD_ORDER_EN
         r_rd_flag  <= 1'b0;
`endif
      end else begin
         r_rx_valid <= 1'b0;
         if ((r_state != ST_IDLE) && SS_n) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if (!SS_n) begin
                     r_state <= ST_RECEIVE;
                     r_cnt   <= '0;
                  end
               end
               ST_RECEIVE: begin
                  r_shift <= {r_shift[DATA_W-1:0], MOSI};
                  if (r_cnt == LAST_RX) begin
                     r_cnt <= '0;
                     if (w_accept) begin
                        r_rx_data  <= w_frame;
                        r_rx_valid <= 1'b1;
                     end
                     if (w_accept && (w_cmd == CMD_RD_DATA)) r_state <= ST_WAIT_TX;
                     else                                    r_state <= ST_DONE;
`ifdef SPI_RD_ORDER_EN
                     if (w_cmd == CMD_RD_ADDR)      r_rd_flag <= 1'b1;
                     else if (w_cmd == CMD_RD_DATA) r_rd_flag <= 1'b0;
`endif
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
               ST_WAIT_TX: begin
                  if (tx_valid) begin
                     r_tx_byte <= tx_data;
                     r_cnt     <= '0;
                     r_state   <= ST_SEND;
                  end
               end
               ST_SEND: begin
                  r_tx_byte <= {r_tx_byte[DATA_W-2:0], 1'b0};
                  if (r_cnt == LAST_TX) begin
                     r_cnt   <= '0;
                     r_state <= ST_DONE;
                  end else begin
                     r_cnt <= r_cnt + 1'b1;
                  end
               end
               ST_DONE: ;
               default: r_state <= ST_IDLE;
            endcase
         end
      end
   end

   // MISO is the MSB of the shifting byte, gated so it is 0 outside SEND.
   assign MISO     = (r_state == ST_SEND) & r_tx_byte[DATA_W-1];
   assign rx_data  = r_rx_data;
   assign rx_valid = r_rx_valid;
   assign o_state  = r_state;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: inputs driven and outputs sampled 1 ns after each rising edge.
module tb_spi_slave;

   logic       clk;
   logic       rst_n;
   logic       SS_n;
   logic       MOSI;
   logic       MISO;
   logic [9:0] rx_data;
   logic       rx_valid;
   logic [7:0] tx_data;
   logic       tx_valid;
   logic [2:0] o_state;

   int n_checks = 0;
   int n_fail   = 0;

   localparam logic [2:0] S_IDLE = 3'd0, S_WAIT = 3'd2, S_SEND = 3'd3, S_DONE = 3'd4;

   spi_slave #(.DATA_W(8)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .SS_n     (SS_n),
      .MOSI     (MOSI),
      .MISO     (MISO),
      .rx_data  (rx_data),
      .rx_valid (rx_valid),
      .tx_data  (tx_data),
      .tx_valid (tx_valid),
      .o_state  (o_state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, act, exp, $time);
      end
   endtask

   // Drops SS_n, spends the IDLE cycle, then shifts the frame MSB first.
   task automatic send_frame(input logic [9:0] f);
      logic seen_v;
      logic seen_m;
      seen_v = 1'b0;
      seen_m = 1'b0;
      SS_n = 1'b0;
      MOSI = 1'b0;
      tick;
      for (int i = 0; i < 10; i++) begin
         MOSI   = f[9-i];
         seen_v = seen_v | rx_valid;
         seen_m = seen_m | MISO;
         tick;
      end
      MOSI = 1'b0;
      check("rx_valid_during_frame", {31'd0, seen_v}, 32'd0);
      check("miso_during_frame", {31'd0, seen_m}, 32'd0);
   endtask

   task automatic deselect;
      SS_n = 1'b1;
      tick;
   endtask

   initial begin
      logic [7:0] exp_byte;
      logic       seen_m;

      rst_n = 1'b0; SS_n = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_data = 8'h00;
      tick; tick;
      check("reset_rx_data", 32'(rx_data), 32'h0);
      check("reset_rx_valid", 32'(rx_valid), 32'h0);
      check("reset_miso", 32'(MISO), 32'h0);
      check("reset_state", 32'(o_state), 32'(S_IDLE));
      rst_n = 1'b1;
      tick;

      // Write-address frame; stray tx_valid in DONE must be ignored.
      send_frame(10'h0A5);
      check("wr_addr_rx_valid", 32'(rx_valid), 32'h1);
      check("wr_addr_rx_data", 32'(rx_data), 32'h0A5);
      check("wr_addr_state", 32'(o_state), 32'(S_DONE));
      tx_valid = 1'b1; tx_data = 8'hFF;
      tick;
      tx_valid = 1'b0;
      check("wr_addr_rx_valid_drop", 32'(rx_valid), 32'h0);
      check("done_ignores_tx_state", 32'(o_state), 32'(S_DONE));
      check("done_ignores_tx_miso", 32'(MISO), 32'h0);
      deselect;
      check("deselect_idle", 32'(o_state), 32'(S_IDLE));
      check("rx_data_hold", 32'(rx_data), 32'h0A5);

      // Read-address then read-data, back to back, with a 0x3C reply.
      send_frame(10'h2FF);
      check("rd_addr_rx_data", 32'(rx_data), 32'h2FF);
      check("rd_addr_state", 32'(o_state), 32'(S_DONE));
      deselect;
      send_frame(10'h300);
      check("rd_data_rx_valid", 32'(rx_valid), 32'h1);
      check("rd_data_rx_data", 32'(rx_data), 32'h300);
      check("rd_data_state", 32'(o_state), 32'(S_WAIT));
      tick;
      check("rd_data_rx_valid_drop", 32'(rx_valid), 32'h0);
      check("wait_miso", 32'(MISO), 32'h0);
      tx_valid = 1'b1; tx_data = 8'h3C;
      tick;
      tx_valid = 1'b0;
      check("send_state", 32'(o_state), 32'(S_SEND));
      exp_byte = 8'h3C;
      for (int i = 0; i < 8; i++) begin
         check($sformatf("miso_bit%0d", 7 - i), 32'(MISO), 32'(exp_byte[7-i]));
         tick;
      end
      check("miso_after_send", 32'(MISO), 32'h0);
      check("state_after_send", 32'(o_state), 32'(S_DONE));
      deselect;

      // Partial frame aborted after 5 bits, then a full write-data frame.
      SS_n = 1'b0;
      tick;
      for (int i = 0; i < 5; i++) begin
         MOSI = i[0];
         tick;
      end
      SS_n = 1'b1;
      tick;
      check("abort_state", 32'(o_state), 32'(S_IDLE));
      check("abort_rx_valid", 32'(rx_valid), 32'h0);
      check("abort_rx_data_hold", 32'(rx_data), 32'h300);
      send_frame(10'h1C3);
      check("wr_data_rx_valid", 32'(rx_valid), 32'h1);
      check("wr_data_rx_data", 32'(rx_data), 32'h1C3);
      check("wr_data_state", 32'(o_state), 32'(S_DONE));
      deselect;

      // Read-data with no tx_valid: parks in WAIT_TX until deselected.
      send_frame(10'h280);
      deselect;
      send_frame(10'h31A);
      check("park_rx_data", 32'(rx_data), 32'h31A);
      seen_m = 1'b0;
      repeat (20) begin
         tick;
         seen_m = seen_m | MISO;
      end
      check("park_state", 32'(o_state), 32'(S_WAIT));
      check("park_miso", 32'(seen_m), 32'h0);
      deselect;
      check("park_exit_state", 32'(o_state), 32'(S_IDLE));
      check("park_exit_miso", 32'(MISO), 32'h0);

      // Reset asserted in the middle of sending 0xFF.
      send_frame(10'h281);
      deselect;
      send_frame(10'h3AB);
      tick;
      tx_valid = 1'b1; tx_data = 8'hFF;
      tick;
      tx_valid = 1'b0;
      tick; tick;
      check("ff_send_miso", 32'(MISO), 32'h1);
      check("ff_send_state", 32'(o_state), 32'(S_SEND));
      rst_n = 1'b0;
      #1;
      check("rst_mid_miso", 32'(MISO), 32'h0);
      check("rst_mid_state", 32'(o_state), 32'(S_IDLE));
      check("rst_mid_rx_valid", 32'(rx_valid), 32'h0);
      check("rst_mid_rx_data", 32'(rx_data), 32'h0);
      SS_n = 1'b1;
      tick; tick;
      rst_n = 1'b1;
      tick;
      check("post_rst_state", 32'(o_state), 32'(S_IDLE));

      // Read-data as the first frame after reset.
      send_frame(10'h355);
`ifdef SPI_RD_ORDER_EN
      check("order_rx_valid", 32'(rx_valid), 32'h0);
      check("order_rx_data", 32'(rx_data), 32'h0);
      check("order_state", 32'(o_state), 32'(S_DONE));
`else
      check("order_rx_valid", 32'(rx_valid), 32'h1);
      check("order_rx_data", 32'(rx_data), 32'h355);
      check("order_state", 32'(o_state), 32'(S_WAIT));
`endif
      tick;
      check("order_miso", 32'(MISO), 32'h0);
      deselect;
      check("final_state", 32'(o_state), 32'(S_IDLE));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
